// File: rtl/punc_dbg_pkg.sv
// punc_dbg_pkg: shared types and constants for the PUnC debug-dump sequencer.
//   word_t       16-bit processor word
//   dump_beat_t  stream payload (data + last marker)
//   state_t      sequencer states
//   idx_width()  bits needed for the word index of a dump of mem_words words
package punc_dbg_pkg;

  typedef logic [15:0] word_t;

  typedef struct packed {
    logic  last;
    word_t data;
  } dump_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_SEND    = 2'd3
  } state_t;

  // PC plus R0..R7 precede the memory window
  localparam int unsigned HDR_WORDS = 9;
  localparam int unsigned PC_IDX    = 0;
  localparam int unsigned RF_FIRST  = 1;
  localparam int unsigned MEM_FIRST = 9;

  // Smallest width that holds the highest index, HDR_WORDS + mem_words - 1
  function automatic int unsigned idx_width(input int unsigned mem_words);
    int unsigned max_idx;
    int unsigned w;
    max_idx = HDR_WORDS + mem_words - 1;
    w = 1;
    while ((max_idx >> w) != 0) w++;
    return w;
  endfunction

endpackage

// File: rtl/punc_debug_dump_if.sv
// punc_debug_dump_if: valid/ready stream carrying one dump word per handshake.
//   valid  word present (master)
//   ready  sink accepts (slave)
//   beat   data + last marker (master)
interface punc_debug_dump_if;
  import punc_dbg_pkg::*;

  logic       valid;
  logic       ready;
  dump_beat_t beat;

  modport master (output valid, output beat, input ready);
  modport slave  (input valid, input beat, output ready);
endinterface

// File: rtl/punc_dbg_out_reg.sv
// punc_dbg_out_reg: output holding register for the dump stream.
//   clk, rst    clock, synchronous active-high reset
//   load        capture load_beat and raise valid
//   load_beat   word and last marker to present
//   out_if      stream master; valid held until the handshake
module punc_dbg_out_reg
  import punc_dbg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  dump_beat_t         load_beat,
  punc_debug_dump_if.master  out_if
);

  // Payload is only rewritten on load, so it stays stable while waiting for ready
  always_ff @(posedge clk) begin
    if (rst) begin
      out_if.valid <= 1'b0;
      out_if.beat  <= '0;
    end else if (load) begin
      out_if.valid <= 1'b1;
      out_if.beat  <= load_beat;
    end else if (out_if.valid && out_if.ready) begin
      out_if.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/punc_debug_dump.sv
// punc_debug_dump: walks the PUnC debug read ports and streams PC, R0..R7 and
// MEM_WORDS memory words starting at mem_base over a valid/ready stream.
//   clk, rst          clock, synchronous active-high reset
//   start, mem_base   dump request (IDLE only) and first memory address
//   busy, done        dump in progress / one-cycle completion pulse
//   mem_debug_addr    memory debug address, rf_debug_addr register debug address
//   *_debug_data      processor debug read data
//   out_if            stream master (valid, ready, beat.data, beat.last)
module punc_debug_dump
  import punc_dbg_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  word_t              mem_base,
  output logic               busy,
  output logic               done,
  output word_t              mem_debug_addr,
  output logic [2:0]         rf_debug_addr,
  input  word_t              mem_debug_data,
  input  word_t              rf_debug_data,
  input  word_t              pc_debug_data,
  punc_debug_dump_if.master  out_if
);

  localparam int unsigned IDX_W    = idx_width(MEM_WORDS);
  localparam int unsigned LAST_IDX = HDR_WORDS + MEM_WORDS - 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
  word_t            base_q, base_d;
  word_t            mem_addr_q, mem_addr_d;
  logic [2:0]       rf_addr_q, rf_addr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_c;
  dump_beat_t       beat_c;
  logic             hs_c;
  word_t            src_c;

  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_debug_addr = mem_addr_q;
  assign rf_debug_addr  = rf_addr_q;

  assign hs_c    = out_if.valid && out_if.ready;
  assign idx_inc = idx_q + IDX_W'(1);

  // Source selected by the current index; addresses have been stable since SETUP
  always_comb begin
    if (idx_q == IDX_W'(PC_IDX))
      src_c = pc_debug_data;
    else if (idx_q < IDX_W'(MEM_FIRST))
      src_c = rf_debug_data;
    else
      src_c = mem_debug_data;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      base_q     <= '0;
      mem_addr_q <= '0;
      rf_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      mem_addr_q <= mem_addr_d;
      rf_addr_q  <= rf_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state, index and address generation
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    base_d     = base_q;
    mem_addr_d = mem_addr_q;
    rf_addr_d  = rf_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_c     = 1'b0;
    beat_c     = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = mem_base;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end

      // Addresses were registered on entry; this cycle lets a registered read settle
      ST_SETUP: state_d = ST_CAPTURE;

      ST_CAPTURE: begin
        load_c      = 1'b1;
        beat_c.data = src_c;
        beat_c.last = (idx_q == IDX_W'(LAST_IDX));
        state_d     = ST_SEND;
      end

      ST_SEND: begin
        if (hs_c) begin
          if (out_if.beat.last) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_inc;
            state_d = ST_SETUP;
            // Point the debug port at the next word before SETUP begins
            if (idx_inc >= IDX_W'(MEM_FIRST))
              mem_addr_d = base_q + 16'(idx_inc - IDX_W'(MEM_FIRST));
            else
              rf_addr_d = 3'(idx_inc - IDX_W'(RF_FIRST));
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  punc_dbg_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .load_beat (beat_c),
    .out_if    (out_if)
  );

endmodule

// File: tb/tb_punc_debug_dump.sv
// tb_punc_debug_dump: directed checks of the debug-dump sequencer with MEM_WORDS=4.
// The processor is modelled combinationally: PC=0x3000, Rk=0x1110+k,
// mem[a]=0xA000+(a-0x3000).
module tb_punc_debug_dump;

  localparam int N_WORDS = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] mem_base;
  logic        busy;
  logic        done;
  logic [15:0] mem_debug_addr;
  logic [2:0]  rf_debug_addr;
  logic [15:0] mem_debug_data;
  logic [15:0] rf_debug_data;
  logic [15:0] pc_debug_data;

  punc_debug_dump_if s_if ();

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c_acc = 0;

  logic [15:0] exp_w [0:N_WORDS-1];
  logic [15:0] exp_a [0:N_WORDS-1];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign pc_debug_data  = 16'h3000;
  assign rf_debug_data  = 16'h1110 + {13'd0, rf_debug_addr};
  assign mem_debug_data = 16'hA000 + (mem_debug_addr - 16'h3000);

  punc_debug_dump #(.MEM_WORDS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mem_base       (mem_base),
    .busy           (busy),
    .done           (done),
    .mem_debug_addr (mem_debug_addr),
    .rf_debug_addr  (rf_debug_addr),
    .mem_debug_data (mem_debug_data),
    .rf_debug_data  (rf_debug_data),
    .pc_debug_data  (pc_debug_data),
    .out_if         (s_if)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic fill_exp(input logic [15:0] base, input logic [15:0] m0,
                          input logic [15:0] m1, input logic [15:0] m2,
                          input logic [15:0] m3);
    exp_w[0] = 16'h3000;
    for (int k = 0; k < 8; k++) exp_w[1+k] = 16'h1110 + 16'(k);
    for (int j = 0; j < 4; j++) exp_a[9+j] = base + 16'(j);
    exp_w[9]  = m0;
    exp_w[10] = m1;
    exp_w[11] = m2;
    exp_w[12] = m3;
  endtask

  // Called at a negedge; start is seen by the next posedge, so this cycle is the accept cycle
  task automatic do_start(input logic [15:0] base);
    start    = 1'b1;
    mem_base = base;
    c_acc    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Collect one dump; returns at the negedge following the final handshake
  task automatic run_dump(input bit rnd, input bit poke, input bit chk_len);
    int          n;
    int          guard;
    int          hs_cyc;
    bit          seen;
    bit          hold;
    logic [15:0] pdata;
    logic        plast;
    n = 0; guard = 0; hs_cyc = 0; seen = 0; hold = 0; pdata = '0; plast = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'(1));
    while (n < N_WORDS && guard < 400) begin
      if (hold) begin
        chk("hold_valid", 32'(s_if.valid), 32'(1));
        chk("hold_data", 32'(s_if.beat.data), 32'(pdata));
        chk("hold_last", 32'(s_if.beat.last), 32'(plast));
      end
      if (s_if.valid && !seen) begin
        seen = 1;
        chk("first_valid_latency", cyc - c_acc, 32'(3));
      end
      start      = poke && (n == 4);
      s_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hold       = s_if.valid && !s_if.ready;
      pdata      = s_if.beat.data;
      plast      = s_if.beat.last;
      if (s_if.valid && s_if.ready) begin
        chk($sformatf("word%0d_data", n), 32'(s_if.beat.data), 32'(exp_w[n]));
        chk($sformatf("word%0d_last", n), 32'(s_if.beat.last), 32'(n == N_WORDS - 1));
        if (n >= 9)
          chk($sformatf("word%0d_addr", n), 32'(mem_debug_addr), 32'(exp_a[n]));
        hs_cyc = cyc;
        n++;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    if (n != N_WORDS) begin
      chk("stream_timeout_words", n, N_WORDS);
    end else begin
      chk("done_pulse", 32'(done), 32'(1));
      chk("busy_after_last", 32'(busy), 32'(0));
      chk("valid_after_last", 32'(s_if.valid), 32'(0));
      if (chk_len) chk("dump_length", hs_cyc - c_acc, 32'(39));
    end
  endtask

  initial begin
    int  n;
    int  guard;
    int  cnt;
    bit  seen_done;
    bit  seen_valid;

    rst = 1'b1; start = 1'b0; mem_base = '0; s_if.ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values, then 20 idle cycles
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_valid", 32'(s_if.valid), 32'(0));
    chk("rst_last", 32'(s_if.beat.last), 32'(0));
    chk("rst_data", 32'(s_if.beat.data), 32'(0));
    seen_done = 0; seen_valid = 0;
    repeat (20) begin
      @(negedge clk);
      seen_done  |= done;
      seen_valid |= s_if.valid;
    end
    chk("idle_no_done", 32'(seen_done), 32'(0));
    chk("idle_no_valid", 32'(seen_valid), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_mem_addr", 32'(mem_debug_addr), 32'(0));
    chk("idle_rf_addr", 32'(rf_debug_addr), 32'(0));

    // Full-rate dump, then a second start in the done cycle
    fill_exp(16'h3000, 16'hA000, 16'hA001, 16'hA002, 16'hA003);
    do_start(16'h3000);
    run_dump(1'b0, 1'b0, 1'b1);
    do_start(16'h3000);
    run_dump(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'(0));

    // Back-pressure from a random ready
    do_start(16'h3000);
    run_dump(1'b1, 1'b0, 1'b0);
    s_if.ready = 1'b1;
    @(negedge clk);

    // Memory window wrapping past 0xFFFF
    fill_exp(16'hFFFE, 16'h6FFE, 16'h6FFF, 16'h7000, 16'h7001);
    do_start(16'hFFFE);
    run_dump(1'b0, 1'b0, 1'b1);
    @(negedge clk);

    // start pulsed mid-dump is ignored
    fill_exp(16'h3000, 16'hA000, 16'hA001, 16'hA002, 16'hA003);
    do_start(16'h3000);
    run_dump(1'b0, 1'b1, 1'b1);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (s_if.valid || busy) cnt++;
    end
    chk("no_second_stream", cnt, 32'(0));

    // Reset while word 5 is in SEND
    do_start(16'h3000);
    n = 0; guard = 0;
    s_if.ready = 1'b1;
    while (!(n == 5 && s_if.valid) && guard < 100) begin
      if (s_if.valid) n++;
      @(negedge clk);
      guard++;
    end
    chk("reach_word5", n, 32'(5));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", 32'(s_if.valid), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_last", 32'(s_if.beat.last), 32'(0));
    chk("midrst_data", 32'(s_if.beat.data), 32'(0));
    chk("midrst_rf_addr", 32'(rf_debug_addr), 32'(0));
    seen_done = 0;
    repeat (10) begin
      @(negedge clk);
      seen_done |= done | s_if.valid;
    end
    chk("midrst_quiet", 32'(seen_done), 32'(0));
    do_start(16'h3000);
    run_dump(1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
